clahe_bram_port_arbiter: RTL

Sequencer and arbiter for one port of the CLAHE true-dual-port histogram BRAM. Two requesters share the port through valid/ready command handshakes: port 0 is the histogram update engine and port 1 is the CDF/readout engine. A built-in clear engine sweeps every address to zero on request. All BRAM control outputs are registered, and read data is routed back to the requester that issued the read, using a latency-matched tag pipeline.

---
 rtl/clahe_bram_port_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/clahe_bram_port_arbiter.sv
// Two-requester arbiter and clear sequencer for one port of the CLAHE histogram BRAM.
// Define CLAHE_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module clahe_bram_port_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 16,
  parameter int BYTEEN_WIDTH = 8,
  parameter int RD_LAT       = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    p0_valid,
  output logic                    p0_ready,
  input  logic                    p0_we,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [DATA_WIDTH-1:0]   p0_wdata,
  input  logic [BYTEEN_WIDTH-1:0] p0_byteen,
  output logic                    p0_rvalid,
  output logic [DATA_WIDTH-1:0]   p0_rdata,
  input  logic                    p1_valid,
  output logic                    p1_ready,
  input  logic                    p1_we,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  input  logic [BYTEEN_WIDTH-1:0] p1_byteen,
  output logic                    p1_rvalid,
  output logic [DATA_WIDTH-1:0]   p1_rdata,
  input  logic                    clr_start,
  output logic                    clr_busy,
  output logic                    clr_done,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_wdata,
  output logic                    bram_clke,
  output logic                    bram_we,
  output logic [BYTEEN_WIDTH-1:0] bram_byteen,
  output logic                    bram_addren,
  output logic                    bram_rst,
  input  logic [DATA_WIDTH-1:0]   bram_rdata
);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]              state_reg;
  logic                    arb_open;
  logic                    contend;
  logic                    win1;
  logic                    accept;
  logic                    cmd_we;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [BYTEEN_WIDTH-1:0] cmd_byteen;
  logic [1:0]              tag_in;
  logic [1:0]              tag_reg [RD_LAT];

`ifdef CLAHE_ARB_RR_EN
  // High means port 1 wins the next contended cycle.
  logic rr_ptr_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_reg <= 1'b0;
    end else if (accept && contend) begin
      rr_ptr_reg <= ~win1;
    end
  end

  always_comb begin
    win1 = contend ? rr_ptr_reg : p1_valid;
  end
`else
  always_comb begin
    win1 = contend ? 1'b0 : p1_valid;
  end
`endif

  always_comb begin
    arb_open   = (state_reg == ST_ARB) && !clr_start;
    contend    = p0_valid && p1_valid;
    p0_ready   = arb_open && p0_valid && !win1;
    p1_ready   = arb_open && p1_valid && win1;
    accept     = p0_ready || p1_ready;
    cmd_we     = win1 ? p1_we     : p0_we;
    cmd_addr   = win1 ? p1_addr   : p0_addr;
    cmd_wdata  = win1 ? p1_wdata  : p0_wdata;
    cmd_byteen = win1 ? p1_byteen : p0_byteen;
    tag_in     = {accept && !cmd_we, win1};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg   <= ST_ARB;
      bram_addr   <= '0;
      bram_wdata  <= '0;
      bram_clke   <= 1'b0;
      bram_we     <= 1'b0;
      bram_byteen <= '0;
      bram_addren <= 1'b0;
      bram_rst    <= 1'b1;
      clr_busy    <= 1'b0;
      clr_done    <= 1'b0;
    end else begin
      bram_rst    <= 1'b0;
      bram_wdata  <= '0;
      bram_clke   <= 1'b0;
      bram_we     <= 1'b0;
      bram_byteen <= '0;
      bram_addren <= 1'b0;
      clr_done    <= 1'b0;
      case (state_reg)
        ST_ARB: begin
          if (clr_start) begin
            state_reg   <= ST_CLEAR;
            clr_busy    <= 1'b1;
            bram_addr   <= '0;
            bram_clke   <= 1'b1;
            bram_we     <= 1'b1;
            bram_addren <= 1'b1;
            bram_byteen <= '1;
          end else if (accept) begin
            bram_addr   <= cmd_addr;
            bram_wdata  <= cmd_wdata;
            bram_clke   <= 1'b1;
            bram_we     <= cmd_we;
            bram_addren <= 1'b1;
            bram_byteen <= cmd_we ? cmd_byteen : '0;
          end
        end
        ST_CLEAR: begin
          // bram_addr doubles as the sweep counter.
          if (&bram_addr) begin
            state_reg <= ST_DONE;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b1;
          end else begin
            bram_addr   <= bram_addr + ADDR_WIDTH'(1);
            bram_clke   <= 1'b1;
            bram_we     <= 1'b1;
            bram_addren <= 1'b1;
            bram_byteen <= '1;
          end
        end
        default: begin
          state_reg <= ST_ARB;
        end
      endcase
    end
  end

  // Tag stage 0 is loaded together with the registered command.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_reg[i] <= 2'b00;
      end
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
    end else begin
      tag_reg[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_reg[i] <= tag_reg[i-1];
      end
      p0_rvalid <= tag_reg[RD_LAT-1][1] && !tag_reg[RD_LAT-1][0];
      p1_rvalid <= tag_reg[RD_LAT-1][1] && tag_reg[RD_LAT-1][0];
    end
  end

  assign p0_rdata = bram_rdata;
  assign p1_rdata = bram_rdata;

endmodule
